// File: rtl/exec_sequencer.sv
// exec_sequencer: four-state execute/writeback controller for the 8-bit CPU.
// Accepts one instruction per handshake, reads two operands from the register
// file, computes the ALU result, and writes it back. It also keeps the carry
// and zero flags.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for an instruction; latches instr on handshake
// READ  | read addresses driven from latched rs1/rs2; operands captured
// EXEC  | ALU evaluates captured operands; result and flags registered
// WB    | write strobe (non-NOP) and done asserted for one cycle
module exec_sequencer #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [8:0]        instr,
    output logic [2:0]        rf_read_addr1,
    output logic [2:0]        rf_read_addr2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write_en,
    output logic [2:0]        rf_write_addr,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              done,
    output logic              busy,
    output logic              carry,
    output logic              zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_EXEC = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [8:0]        instr_q;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] result_q;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              accept;

    logic [2:0] op_q;
    logic [1:0] rd_q;
    logic [1:0] rs1_q;
    logic [1:0] rs2_q;

    assign op_q  = instr_q[8:6];
    assign rd_q  = instr_q[5:4];
    assign rs1_q = instr_q[3:2];
    assign rs2_q = instr_q[1:0];

    // Handshake and Moore status decodes; ready is forced low while reset is held.
    assign instr_ready = (state == S_IDLE) && !rst;
    assign accept      = instr_valid && instr_ready;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_WB);
    assign rf_write_en = (state == S_WB) && (op_q != OP_NOP);

    // Register file addressing; the upper address bit is tied low.
    assign rf_read_addr1 = (state == S_READ) ? {1'b0, rs1_q} : 3'b000;
    assign rf_read_addr2 = (state == S_READ) ? {1'b0, rs2_q} : 3'b000;
    assign rf_write_addr = {1'b0, rd_q};
    assign rf_write_data = result_q;

    // Next-state logic: fixed four-cycle walk once an instruction is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_READ;
            S_READ: state_nxt = S_EXEC;
            S_EXEC: state_nxt = S_WB;
            S_WB:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Instruction latch; held unchanged from accept through WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= '0;
        end else if (accept) begin
            instr_q <= instr;
        end
    end

    // Operand capture at the end of READ so aliased rd/rs need no forwarding.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a <= '0;
            op_b <= '0;
        end else if (state == S_READ) begin
            op_a <= rf_read_data1;
            op_b <= rf_read_data2;
        end
    end

    // ALU on captured operands; SUB carry is the borrow out of the 9-bit difference.
    always_comb begin
        logic [DATA_W:0] wide;
        wide       = '0;
        alu_result = '0;
        alu_carry  = 1'b0;
        case (op_q)
            OP_ADD: begin
                wide       = {1'b0, op_a} + {1'b0, op_b};
                alu_result = wide[DATA_W-1:0];
                alu_carry  = wide[DATA_W];
            end
            OP_SUB: begin
                wide       = {1'b0, op_a} - {1'b0, op_b};
                alu_result = wide[DATA_W-1:0];
                alu_carry  = wide[DATA_W];
            end
            OP_AND: alu_result = op_a & op_b;
            OP_OR:  alu_result = op_a | op_b;
            OP_XOR: alu_result = op_a ^ op_b;
            OP_MOV: alu_result = op_a;
            OP_LDI: alu_result = {{(DATA_W-4){1'b0}}, rs1_q, rs2_q};
            default: begin
                alu_result = '0;
                alu_carry  = 1'b0;
            end
        endcase
    end

    // Result and flags registered at the end of EXEC; NOP leaves all of them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            carry    <= 1'b0;
            zero     <= 1'b0;
        end else if ((state == S_EXEC) && (op_q != OP_NOP)) begin
            result_q <= alu_result;
            carry    <= alu_carry;
            zero     <= (alu_result == '0);
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: register file model, scoreboard fed at accept
// time by an arithmetic reference model, and a monitor that checks each done.
module tb_exec_sequencer;

    typedef struct {
        bit       we;
        bit [2:0] addr;
        bit [7:0] data;
        bit       c;
        bit       z;
        int       cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid;
    logic       instr_ready;
    logic [8:0] instr;
    logic [2:0] rf_read_addr1;
    logic [2:0] rf_read_addr2;
    logic [7:0] rf_read_data1;
    logic [7:0] rf_read_data2;
    logic       rf_write_en;
    logic [2:0] rf_write_addr;
    logic [7:0] rf_write_data;
    logic       done;
    logic       busy;
    logic       carry;
    logic       zero;

    logic [7:0] rf [8] = '{default: 8'h00};
    logic [7:0] mrf [4] = '{default: 8'h00};
    bit         mc = 1'b0;
    bit         mz = 1'b0;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   acc_count = 0;
    int   last_acc = -1;
    bit   held = 1'b0;

    always #5 clk = ~clk;

    exec_sequencer #(.DATA_W(8)) dut (
        .clk(clk),
        .rst(rst),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .rf_read_addr1(rf_read_addr1),
        .rf_read_addr2(rf_read_addr2),
        .rf_read_data1(rf_read_data1),
        .rf_read_data2(rf_read_data2),
        .rf_write_en(rf_write_en),
        .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data),
        .done(done),
        .busy(busy),
        .carry(carry),
        .zero(zero)
    );

    assign rf_read_data1 = rf[rf_read_addr1];
    assign rf_read_data2 = rf[rf_read_addr2];

    always @(posedge clk) begin
        if (rf_write_en) rf[rf_write_addr] <= rf_write_data;
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: behaviour from opcode rules using plain integer arithmetic.
    function automatic exp_t model(input logic [8:0] ins);
        exp_t e;
        int a, b, r, op;
        bit c;
        op = int'(ins[8:6]);
        a  = int'(mrf[ins[3:2]]);
        b  = int'(mrf[ins[1:0]]);
        r  = 0;
        c  = 1'b0;
        case (op)
            0: begin r = a + b; c = (r > 255); r = r % 256; end
            1: begin c = (a < b); r = (a - b + 256) % 256; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = a;
            6: r = int'(ins[3:0]);
            default: r = 0;
        endcase
        e.we   = (op != 7);
        e.addr = {1'b0, ins[5:4]};
        e.data = r[7:0];
        e.c    = (op == 7) ? mc : c;
        e.z    = (op == 7) ? mz : (r == 0);
        e.cyc  = 0;
        return e;
    endfunction

    // Accept logger: pushes the expected response at each handshake edge.
    always @(posedge clk) begin
        exp_t e;
        cyc <= cyc + 1;
        if (!rst && instr_valid && instr_ready) begin
            e = model(instr);
            e.cyc = cyc + 3;
            sb_q.push_back(e);
            acc_count++;
            if (held && last_acc >= 0) chk("accept_spacing", cyc - last_acc, 4);
            last_acc = cyc;
        end
    end

    // Monitor: compares the DUT against the scoreboard away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("we_only_with_done", int'(rf_write_en && !done), 0);
            chk("addr_msb_low", int'(rf_read_addr1[2] | rf_read_addr2[2] | rf_write_addr[2]), 0);
            chk("ready_low_inflight", int'(instr_ready), int'(sb_q.size() == 0));
            if (done) begin
                if (sb_q.size() == 0) begin
                    fail_now("unexpected_done");
                end else begin
                    e = sb_q.pop_front();
                    chk("write_en", int'(rf_write_en), int'(e.we));
                    if (e.we) begin
                        chk("write_addr", int'(rf_write_addr), int'(e.addr));
                        chk("write_data", int'(rf_write_data), int'(e.data));
                        mrf[e.addr[1:0]] = e.data;
                    end
                    chk("carry", int'(carry), int'(e.c));
                    chk("zero", int'(zero), int'(e.z));
                    chk("done_latency", cyc, e.cyc);
                    mc = e.c;
                    mz = e.z;
                end
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] rd,
                         input logic [1:0] rs1, input logic [1:0] rs2);
        int n;
        bit got;
        n = acc_count;
        got = 1'b0;
        instr_valid = 1'b1;
        instr = {op, rd, rs1, rs2};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (acc_count != n) begin
                got = 1'b1;
                break;
            end
        end
        instr_valid = 1'b0;
        if (!got) fail_now("accept_timeout");
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("idle_timeout");
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;

        // Reset held for two cycles.
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", int'(instr_ready), 0);
            chk("rst_we", int'(rf_write_en), 0);
            chk("rst_carry", int'(carry), 0);
            chk("rst_zero", int'(zero), 0);
            chk("rst_busy", int'(busy), 0);
            chk("rst_wdata", int'(rf_write_data), 0);
        end
        rst = 1'b0;
        #1;
        chk("post_rst_ready", int'(instr_ready), 1);
        chk("post_rst_busy", int'(busy), 0);

        // LDI / ADD.
        issue(3'b110, 2'd1, 2'd3, 2'd3); wait_idle();
        issue(3'b110, 2'd2, 2'd0, 2'd1); wait_idle();
        issue(3'b000, 2'd3, 2'd1, 2'd2); wait_idle();
        chk("R1_ldi", int'(rf[1]), 'h0F);
        chk("R2_ldi", int'(rf[2]), 'h01);
        chk("R3_add", int'(rf[3]), 'h10);
        chk("add_carry", int'(carry), 0);
        chk("add_zero", int'(zero), 0);

        // Flags.
        issue(3'b001, 2'd3, 2'd2, 2'd1); wait_idle();
        chk("R3_sub", int'(rf[3]), 'hF2);
        chk("sub_borrow", int'(carry), 1);
        issue(3'b000, 2'd0, 2'd3, 2'd3); wait_idle();
        chk("R0_add", int'(rf[0]), 'hE4);
        chk("add_carry_out", int'(carry), 1);
        issue(3'b100, 2'd3, 2'd3, 2'd3); wait_idle();
        chk("R3_xor", int'(rf[3]), 'h00);
        chk("xor_zero", int'(zero), 1);
        chk("xor_carry", int'(carry), 0);
        issue(3'b111, 2'd3, 2'd1, 2'd1); wait_idle();
        chk("nop_R3", int'(rf[3]), 'h00);
        chk("nop_zero_hold", int'(zero), 1);
        chk("nop_carry_hold", int'(carry), 0);

        // Aliasing.
        issue(3'b000, 2'd1, 2'd1, 2'd1); wait_idle();
        chk("R1_alias", int'(rf[1]), 'h1E);
        issue(3'b101, 2'd2, 2'd1, 2'd0); wait_idle();
        chk("R2_mov", int'(rf[2]), 'h1E);

        // Held valid with a changing instruction every cycle.
        held = 1'b1;
        last_acc = -1;
        instr_valid = 1'b1;
        repeat (40) begin
            instr = 9'($urandom);
            @(negedge clk);
        end
        instr_valid = 1'b0;
        held = 1'b0;
        wait_idle();

        // Random instructions with random gaps.
        for (int k = 0; k < 150; k++) begin
            issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle();

        // Reset during EXEC aborts the instruction.
        issue(3'b110, 2'd1, 2'd3, 2'd3); wait_idle();
        issue(3'b000, 2'd1, 2'd1, 2'd1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        sb_q.delete();
        mc = 1'b0;
        mz = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_we", int'(rf_write_en), 0);
        chk("abort_carry", int'(carry), 0);
        chk("abort_zero", int'(zero), 0);
        chk("abort_ready", int'(instr_ready), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_release_ready", int'(instr_ready), 1);
        chk("abort_release_busy", int'(busy), 0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_no_write", int'(rf_write_en), 0);
        end
        chk("abort_R1_kept", int'(rf[1]), 'h0F);

        // Final consistency between register file and model.
        chk("sb_empty", sb_q.size(), 0);
        for (int i = 0; i < 4; i++) chk("rf_vs_model", int'(rf[i]), int'(mrf[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
